// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus.
// At most one requester owns the bus at a time, and its active-low buffer enable is driven low.
// Every change of owner passes through TURNAROUND cycles with all enables high, so two drivers never overlap.
// An owner is forced off after MAX_HOLD cycles, but only when another requester is waiting.
// All outputs are flops with asynchronous reset, so reset_n low disables every driver without a clock edge.
//
// Handshake: req is a level that is sampled on every rising edge and never latched.
// gnt[i] is high while requester i owns the bus. The owner keeps the bus for as long as it holds req[i] high,
// subject to the MAX_HOLD limit when others are waiting. Dropping req[i] releases the bus on the next edge.
module tristate_bus_arbiter #(
   parameter int N          = 4,
   parameter int MAX_HOLD   = 8,
   parameter int TURNAROUND = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N-1:0]           req,
   output logic [N-1:0]           gnt,
   output logic [N-1:0]           en_n,
   output logic [$clog2(N)-1:0]   sel,
   output logic                   busy,
   output logic [1:0]             state_dbg
);

   localparam int SW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam int TW = $clog2(TURNAROUND + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [N-1:0]    gnt_nx;
   logic [SW-1:0]   sel_nx;
   logic [SW-1:0]   last, last_nx;
   logic            busy_nx;
   logic [HW-1:0]   hold_cnt, hold_nx;
   logic [TW-1:0]   turn_cnt, turn_nx;

   logic [SW-1:0]   win;
   logic [SW-1:0]   idx;
   logic            found;
   logic            others_wait;
   logic            hold_full;

   assign state_dbg = state;

   // Round-robin winner: the first set bit of req, searching upward from the slot after the last owner.
   always_comb begin
      win   = last;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = SW'((int'(last) + 1 + i) % N);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   assign others_wait = |(req & ~gnt);
   assign hold_full   = (hold_cnt == HW'(MAX_HOLD));

   // Next-state and next-output logic. Outputs are computed one cycle ahead so they can be registered.
   always_comb begin
      state_nx = state;
      gnt_nx   = gnt;
      sel_nx   = sel;
      last_nx  = last;
      busy_nx  = busy;
      hold_nx  = hold_cnt;
      turn_nx  = turn_cnt;
      case (state)
         IDLE: begin
            gnt_nx  = '0;
            busy_nx = 1'b0;
            if (found) begin
               state_nx    = GRANT;
               gnt_nx      = '0;
               gnt_nx[win] = 1'b1;
               sel_nx      = win;
               last_nx     = win;
               busy_nx     = 1'b1;
               hold_nx     = HW'(1);
            end
         end
         GRANT: begin
            // The owner leaves when it drops its request, or when it has used its hold budget while others wait.
            if (!req[sel] || (hold_full && others_wait)) begin
               state_nx = TURN;
               gnt_nx   = '0;
               busy_nx  = 1'b0;
               turn_nx  = TW'(1);
            end else if (!hold_full) begin
               hold_nx = hold_cnt + HW'(1);
            end
         end
         TURN: begin
            if (turn_cnt == TW'(TURNAROUND)) begin
               turn_nx = '0;
               if (found) begin
                  state_nx    = GRANT;
                  gnt_nx      = '0;
                  gnt_nx[win] = 1'b1;
                  sel_nx      = win;
                  last_nx     = win;
                  busy_nx     = 1'b1;
                  hold_nx     = HW'(1);
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               turn_nx = turn_cnt + TW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            gnt_nx   = '0;
            busy_nx  = 1'b0;
         end
      endcase
   end

   // State and output registers. Reset forces all enables high immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         gnt      <= '0;
         en_n     <= '1;
         sel      <= '0;
         last     <= SW'(N - 1);
         busy     <= 1'b0;
         hold_cnt <= '0;
         turn_cnt <= '0;
      end else begin
         state    <= state_nx;
         gnt      <= gnt_nx;
         en_n     <= ~gnt_nx;
         sel      <= sel_nx;
         last     <= last_nx;
         busy     <= busy_nx;
         hold_cnt <= hold_nx;
         turn_cnt <= turn_nx;
      end
   end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter (N=4, MAX_HOLD=4, TURNAROUND=1).
// A cycle-level ownership model feeds an expected queue, which is checked every cycle.
// Directed scenarios pin the model with literal expectations, followed by a randomized request phase.
module tb_tristate_bus_arbiter;

   localparam int N  = 4;
   localparam int MH = 4;
   localparam int TA = 1;
   localparam int W  = N + 2 + 1;

   logic         clk;
   logic         reset_n;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic [N-1:0] en_n;
   logic [1:0]   sel;
   logic         busy;
   logic [1:0]   state_dbg;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] exp_q[$];

   logic [3:0] full_tbl [0:21] = '{4'h0,
      4'h1, 4'h1, 4'h1, 4'h1, 4'h0,
      4'h2, 4'h2, 4'h2, 4'h2, 4'h0,
      4'h4, 4'h4, 4'h4, 4'h4, 4'h0,
      4'h8, 4'h8, 4'h8, 4'h8, 4'h0,
      4'h1};

   tristate_bus_arbiter #(.N(N), .MAX_HOLD(MH), .TURNAROUND(TA)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .gnt       (gnt),
      .en_n      (en_n),
      .sel       (sel),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   // Ownership model: who holds the bus, how long it has held it, and how many gap cycles remain.
   int m_owner, m_hold, m_gap, m_last, m_sel;

   function automatic int pick(input logic [N-1:0] r, input int last);
      for (int i = 1; i <= N; i++) begin
         if (r[(last + i) % N]) return (last + i) % N;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] model_vec();
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return {g, 2'(m_sel), (m_owner >= 0)};
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_owner = -1; m_hold = 0; m_gap = 0; m_last = N - 1; m_sel = 0;
         exp_q.delete();
         exp_q.push_back(model_vec());
      end else begin
         int w;
         logic [N-1:0] mine;
         if (m_owner >= 0) begin
            mine = '0;
            mine[m_owner] = 1'b1;
            if (!req[m_owner] || (m_hold >= MH && (req & ~mine) != 0)) begin
               m_owner = -1;
               m_gap   = TA;
            end else if (m_hold < MH) begin
               m_hold++;
            end
         end else if (m_gap > 1) begin
            m_gap--;
         end else begin
            m_gap = 0;
            w = pick(req, m_last);
            if (w >= 0) begin
               m_owner = w; m_last = w; m_sel = w; m_hold = 1;
            end
         end
         exp_q.push_back(model_vec());
      end
   end

   // scoreboard compare, once per cycle away from the active edge
   logic [N-1:0] prev_gnt = '0;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] v;
         logic [N-1:0] eg, een;
         v   = exp_q.pop_front();
         eg  = v[W-1:3];
         een = ~eg;
         check("gnt", gnt, eg);
         check("en_n", en_n, een);
         check("sel", sel, v[2:1]);
         check("busy", busy, v[0]);
         check("one_enable", ($countones(~en_n) <= 1), 1);
         check("owner_gap", !(prev_gnt != 0 && gnt != 0 && gnt != prev_gnt), 1);
         prev_gnt = gnt;
      end
   end

   // driver tasks
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      req     = '0;
      cycles(3);

      // full contention from reset: release reset and raise all requests in cycle 0
      reset_n = 1'b1;
      req     = 4'b1111;
      for (int c = 1; c <= 21; c++) begin
         @(negedge clk);
         check("full_contention", gnt, full_tbl[c]);
      end
      req = '0;
      cycles(4);

      // single requester
      req = 4'b0100;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         check("single_gnt", gnt, 4'b0100);
         check("single_en_n", en_n, 4'b1011);
         check("single_sel", sel, 2);
         check("single_busy", busy, 1);
      end
      req = '0;
      @(negedge clk);
      check("single_rel_gnt", gnt, 4'b0000);
      check("single_rel_en_n", en_n, 4'b1111);
      @(negedge clk);
      check("single_idle", state_dbg, 2'd0);
      cycles(2);

      // no contention, then a late competitor against a saturated hold count
      req = 4'b1000;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         check("nocont_gnt", gnt, 4'b1000);
      end
      req = 4'b1001;
      @(negedge clk);
      check("nocont_turn", en_n, 4'b1111);
      @(negedge clk);
      check("nocont_next", gnt, 4'b0001);
      req = '0;
      cycles(4);

      // simultaneous release and request
      req = 4'b0010;
      cycles(3);
      check("simul_owner", gnt, 4'b0010);
      req = 4'b0100;
      @(negedge clk);
      check("simul_turn", en_n, 4'b1111);
      check("simul_turn_busy", busy, 0);
      @(negedge clk);
      check("simul_next", gnt, 4'b0100);
      req = '0;
      cycles(4);

      // asynchronous reset while requester 1 owns the bus
      req = 4'b0010;
      cycles(3);
      check("areset_owner", gnt, 4'b0010);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("areset_gnt", gnt, 4'b0000);
      check("areset_en_n", en_n, 4'b1111);
      check("areset_busy", busy, 0);
      cycles(2);
      reset_n = 1'b1;
      @(negedge clk);
      check("areset_regrant", gnt, 4'b0010);
      req = '0;
      cycles(4);

      // randomized requests
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      end
      req = '0;
      cycles(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
